// File: rtl/alu_pkg.sv
// Function codes and FSM state type shared by the ALU result selector and the
// HI/LO multiply unit.
package alu_pkg;

    localparam logic [5:0] ALU   = 6'd63;
    localparam logic [5:0] SHIFT = 6'd62;
    localparam logic [5:0] HI    = 6'd61;
    localparam logic [5:0] LO    = 6'd60;
    localparam logic [5:0] MULTU = 6'd25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multu_step.sv
// One radix-2 shift-add iteration of the unsigned multiplier (purely combinational).
module multu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_acc_hi,
    input  logic [WIDTH-1:0] i_acc_lo,
    input  logic [WIDTH-1:0] i_mcand,
    output logic [WIDTH-1:0] o_acc_hi,
    output logic [WIDTH-1:0] o_acc_lo
);

    logic [WIDTH:0] w_addend;
    logic [WIDTH:0] w_sum;

    assign w_addend = i_acc_lo[0] ? {1'b0, i_mcand} : '0;
    assign w_sum    = {1'b0, i_acc_hi} + w_addend;

    // The add's carry-out becomes the new top bit of acc_hi after the shift.
    assign o_acc_hi = w_sum[WIDTH:1];
    assign o_acc_lo = {w_sum[0], i_acc_lo[WIDTH-1:1]};

endmodule

// File: rtl/multu_hilo.sv
// Sequential 32x32 unsigned multiplier (MULTU) owning the architectural HI/LO pair;
// HI/LO only change when a completed product is committed.
module multu_hilo
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       signal,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_mcand;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic             w_accept;

    assign w_accept = start && (signal == MULTU);

    multu_step #(.WIDTH(WIDTH)) u_step (
        .i_acc_hi (r_acc_hi),
        .i_acc_lo (r_acc_lo),
        .i_mcand  (r_mcand),
        .o_acc_hi (w_step_hi),
        .o_acc_lo (w_step_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = RUN;
            RUN:     if (r_cnt == CNT_LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
    end

    // The last RUN step's result goes straight into HI/LO at the RUN->DONE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_mcand  <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= dataA;
                        r_acc_hi <= '0;
                        r_acc_lo <= dataB;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_hi <= w_step_hi;
                        r_lo <= w_step_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_out = r_hi;
    assign lo_out = r_lo;

endmodule

// File: doc/multu_hilo.md
# multu_hilo

Sequential 32×32 unsigned multiplier that owns the HI/LO register pair for the ALU. It executes the MULTU function code (6'd25) with a radix-2 shift-add datapath over 32 cycles. It then commits the 64-bit product to architectural HI/LO registers. Its `hi_out`/`lo_out` directly drive the HI/LO inputs of the result selector, which serves HI (6'd61) and LO (6'd60) reads.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `signal`  input  6  function code; a multiply is requested only when it equals MULTU (6'd25).
- `start`  input  1  request strobe; qualified by `signal` == MULTU.
- `dataA`  input  `WIDTH`  multiplicand, unsigned.
- `dataB`  input  `WIDTH`  multiplier, unsigned.
- `busy`  output  1  high while in RUN or DONE.
- `done`  output  1  single-cycle completion pulse.
- `hi_out`  output  `WIDTH`  architectural HI, upper half of the last committed product.
- `lo_out`  output  `WIDTH`  architectural LO, lower half of the last committed product.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE → RUN:** taken when `start` && `signal` == MULTU.
  - Latch `dataA` into `mcand`.
  - Load working product `{acc_hi, acc_lo}` = {0, `dataB`}.
  - Clear `cnt` (5 bits) to 0.
- **RUN, each cycle:**
  - Form a 33-bit sum = {1'b0, `acc_hi`} + (`acc_lo`[0] ? `mcand` : 0).
  - Shift the 65-bit {sum, `acc_lo`} right by 1 into {`acc_hi`, `acc_lo`}. The carry must be kept; dropping bit 32 of the sum is a defect.
  - `cnt` increments.
- **RUN → DONE:** taken on the cycle `cnt` == 31. The final shifted value is written into `hi_out`/`lo_out` at that same edge.
- **DONE → IDLE:** unconditional.
- **HI/LO hold rule:** `hi_out`/`lo_out` change only on commit.
  - During RUN they hold the previous product, so HI/LO reads during a multiply return the old values.
- **Requests outside IDLE:** `start` in RUN or DONE is ignored, not queued. Operand changes after acceptance have no effect.
- **Other codes:** `start` with `signal` ≠ MULTU is ignored. No state or HI/LO change.
- **Width rule:** the result is the exact 64-bit unsigned product. There is no overflow.

## Timing
- **Reset values:**
  - state = IDLE
  - `busy` = 0, `done` = 0
  - `hi_out` = 0, `lo_out` = 0
  - `acc_hi`, `acc_lo`, `mcand`, `cnt` = 0
- **Acceptance:** request sampled at edge E0.
  - `busy` = 1 from E0 through the DONE cycle.
  - RUN occupies cycles 1..32 after E0.
  - DONE occupies cycle 33, with `done` = 1 for exactly that cycle.
  - New `hi_out`/`lo_out` are valid from cycle 33 onward.
- **Latency:** 33 cycles from acceptance to `done`.
- **Throughput:** the earliest next acceptance is the edge ending DONE + 1, so 34 cycles per multiply.
- **Reset mid-operation:** `rst_n` low at any time immediately forces IDLE and clears HI/LO to 0. The aborted product is never committed, and `done` never pulses for it.
- **Simultaneous events:** `start` coincident with the DONE cycle is ignored. Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Shared package `alu_pkg`:**
  - Function-code constants: ALU = 6'd63, SHIFT = 6'd62, HI = 6'd61, LO = 6'd60, MULTU = 6'd25.
  - State enum for {IDLE, RUN, DONE}.
  - The selector and this block must both reference `alu_pkg` for the codes; no local literals.
- **Sub-module `multu_step`:** purely combinational. It takes (`acc_hi`, `acc_lo`, `mcand`) and returns the next {`acc_hi`, `acc_lo`}, containing the 33-bit add and the shift. The FSM, counter and HI/LO registers stay in `multu_hilo`.

## Test plan
- **Basic product:** reset, then `start`, `signal` = 25, `dataA` = 3, `dataB` = 5.
  - `done` at cycle 33.
  - `hi_out` = 0x00000000, `lo_out` = 0x0000000F.
  - `busy` is high for cycles 1–33 only.
- **Maximum operands:** `dataA` = `dataB` = 0xFFFFFFFF → `hi_out` = 0xFFFFFFFE, `lo_out` = 0x00000001. This checks carry retention.
- **Wrong function code:** `start` with `signal` = 61 → `busy` stays 0, HI/LO unchanged.
  - Then run 0x10000 × 0x10000 → `hi_out` = 0x00000001, `lo_out` = 0.
- **Hold and ignore during RUN:** complete 7 × 6, then issue 2 × 2.
  - At cycle 10, pulse `start` with 9 × 9.
  - Required: `lo_out` reads 42 until commit, then becomes 4. The 9 × 9 request is never executed, and only one `done` pulse occurs.
- **Reset mid-run:** assert `rst_n` = 0 at cycle 15 of a 0x12345678 × 0x9ABCDEF0 multiply.
  - Immediately: `busy` = 0 and HI/LO = 0.
  - After release, no `done` appears.
  - A fresh request then yields `hi_out` = 0x0B00EA4E, `lo_out` = 0x242D2080.
- **Back-to-back throughput:** assert `start` on the cycle after `done` (1 × 0, then 0xFFFFFFFF × 2).
  - Accepted with 34-cycle spacing.
  - Final `hi_out` = 0x00000001, `lo_out` = 0xFFFFFFFE.
